// File: rtl/mdu_ctrl.sv
// HI/LO owner: multi-cycle mult/div sequencer with mthi/mtlo and busy for the hazard unit.
// Optional madd/maddu/msub/msubu support when MDU_MADD_EN is defined.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    typedef enum logic {IDLE, RUN} stateT;

    localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

    stateT       state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic        commit;
    logic [31:0] pendHi, pendLo;

    logic isMul, isMulU, isDiv, isDivU, isMthi, isMtlo, isMac;
    logic mdClass, mulClass, accept;
`ifdef MDU_MADD_EN
    logic macSigned, macSub;
`endif

    always_comb begin
        isMul  = 1'b0;
        isMulU = 1'b0;
        isDiv  = 1'b0;
        isDivU = 1'b0;
        isMthi = 1'b0;
        isMtlo = 1'b0;
        isMac  = 1'b0;
`ifdef MDU_MADD_EN
        macSigned = 1'b0;
        macSub    = 1'b0;
`endif
        unique case (op)
            4'd1: isMul  = 1'b1;
            4'd2: isMulU = 1'b1;
            4'd3: isDiv  = 1'b1;
            4'd4: isDivU = 1'b1;
            4'd5: isMthi = 1'b1;
            4'd6: isMtlo = 1'b1;
`ifdef MDU_MADD_EN
            4'd7: begin isMac = 1'b1; macSigned = 1'b1; end
            4'd8: isMac = 1'b1;
            4'd9: begin isMac = 1'b1; macSigned = 1'b1; macSub = 1'b1; end
            4'd10: begin isMac = 1'b1; macSub = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign mulClass = isMul | isMulU | isMac;
    assign mdClass  = mulClass | isDiv | isDivU;
    assign accept   = start & (state == IDLE) & ~flush
                    & (mdClass | isMthi | isMtlo);
    assign busy     = (state == RUN) | (start & mdClass);

    logic [63:0] sProd, uProd;
    assign sProd = 64'($signed({{32{rs_val[31]}}, rs_val})
                 * $signed({{32{rt_val[31]}}, rt_val}));
    assign uProd = {32'd0, rs_val} * {32'd0, rt_val};

    // Forcing the divisor to 1 on overflow yields quot=0x80000000, rem=0 directly.
    logic        divZero, sOvf;
    logic [31:0] safeDiv, uQuot, uRem;
    logic signed [31:0] sQuot, sRem;
    assign divZero = (rt_val == 32'd0);
    assign sOvf    = (rs_val == 32'h8000_0000) & (rt_val == 32'hFFFF_FFFF);
    assign safeDiv = (divZero | sOvf) ? 32'd1 : rt_val;
    assign sQuot   = $signed(rs_val) / $signed(safeDiv);
    assign sRem    = $signed(rs_val) % $signed(safeDiv);
    assign uQuot   = rs_val / safeDiv;
    assign uRem    = rs_val % safeDiv;

`ifdef MDU_MADD_EN
    logic [63:0] macProd, macRes;
    assign macProd = macSigned ? sProd : uProd;
    assign macRes  = macSub ? ({hi, lo} - macProd) : ({hi, lo} + macProd);
`endif

    logic [63:0] res;
    always_comb begin
        res = {hi, lo};
        unique case (1'b1)
            isMul:  res = sProd;
            isMulU: res = uProd;
            isDiv:  res = divZero ? {hi, lo} : {sRem, sQuot};
            isDivU: res = divZero ? {hi, lo} : {uRem, uQuot};
`ifdef MDU_MADD_EN
            isMac:  res = macRes;
`endif
            default: ;
        endcase
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept & mdClass) begin
                    stateNext = RUN;
                    cntNext   = mulClass ? MULT_LAST : DIV_LAST;
                end
            end
            RUN: begin
                if (flush) begin
                    stateNext = IDLE;
                    cntNext   = 4'd0;
                end else if (cnt == 4'd0) begin
                    stateNext = IDLE;
                    commit    = 1'b1;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
            pendHi <= 32'd0;
            pendLo <= 32'd0;
        end else begin
            done <= commit;
            if (commit) begin
                hi <= pendHi;
                lo <= pendLo;
            end else begin
                if (accept & isMthi) hi <= rs_val;
                if (accept & isMtlo) lo <= rs_val;
            end
            if (accept & mdClass) begin
                pendHi <= res[63:32];
                pendLo <= res[31:0];
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic, mthi/mtlo, flush and reset abort.
// Covers MDU_MADD_EN when defined, otherwise checks op 7 is ignored.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .busy(busy), .hi(hi), .lo(lo), .done(done)
    );

    task automatic go(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
    endtask

    task automatic waitDone(input int limit, output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nCmp++; if (hi !== 32'd0) begin nErr++; $display("FAIL reset_hi: got %h want 0", hi); end
        nCmp++; if (lo !== 32'd0) begin nErr++; $display("FAIL reset_lo: got %h want 0", lo); end
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nCmp++; if (done !== 1'b0) begin nErr++; $display("FAIL reset_done: got %b want 0", done); end
        reset_n = 1'b1;
    endtask

    task automatic test_multu;
        logic eb, ed;
        logic [31:0] eh, el;
        @(negedge clk);
        start = 1'b1; op = 4'd2; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
        #1;
        nCmp++; if (busy !== 1'b1) begin nErr++; $display("FAIL multu_start_busy: got %b want 1", busy); end
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            eb = (k <= 5);
            ed = (k == 6);
            eh = (k >= 6) ? 32'h0000_0001 : 32'd0;
            el = (k >= 6) ? 32'hFFFF_FFFE : 32'd0;
            nCmp++; if (busy !== eb) begin nErr++; $display("FAIL multu_busy c%0d: got %b want %b", k, busy, eb); end
            nCmp++; if (done !== ed) begin nErr++; $display("FAIL multu_done c%0d: got %b want %b", k, done, ed); end
            nCmp++; if (hi !== eh) begin nErr++; $display("FAIL multu_hi c%0d: got %h want %h", k, hi, eh); end
            nCmp++; if (lo !== el) begin nErr++; $display("FAIL multu_lo c%0d: got %h want %h", k, lo, el); end
            @(negedge clk);
        end
    endtask

    task automatic test_mult;
        int w;
        @(negedge clk);
        go(4'd1, 32'hFFFF_FFFD, 32'd7);
        start = 1'b1; op = 4'd5; rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        waitDone(30, w);
        nCmp++; if (w !== 4) begin nErr++; $display("FAIL mult_latency: got %0d want 4", w); end
        nCmp++; if (hi !== 32'hFFFF_FFFF) begin nErr++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        nCmp++; if (lo !== 32'hFFFF_FFEB) begin nErr++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        @(negedge clk);
        nCmp++; if (done !== 1'b0) begin nErr++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_div;
        int w;
        @(negedge clk);
        go(4'd3, 32'hFFFF_FFF9, 32'd2);
        waitDone(30, w);
        nCmp++; if (w !== 10) begin nErr++; $display("FAIL div_latency: got %0d want 10", w); end
        nCmp++; if (lo !== 32'hFFFF_FFFD) begin nErr++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        nCmp++; if (hi !== 32'hFFFF_FFFF) begin nErr++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        @(negedge clk);
        nCmp++; if (done !== 1'b0) begin nErr++; $display("FAIL div_done_pulse: got %b want 0", done); end
        go(4'd4, 32'd5, 32'd0);
        waitDone(30, w);
        nCmp++; if (w !== 10) begin nErr++; $display("FAIL divz_latency: got %0d want 10", w); end
        nCmp++; if (lo !== 32'hFFFF_FFFD) begin nErr++; $display("FAIL divz_lo: got %h want fffffffd", lo); end
        nCmp++; if (hi !== 32'hFFFF_FFFF) begin nErr++; $display("FAIL divz_hi: got %h want ffffffff", hi); end
        @(negedge clk);
        go(4'd4, 32'hFFFF_FFF9, 32'd2);
        waitDone(30, w);
        nCmp++; if (lo !== 32'h7FFF_FFFC) begin nErr++; $display("FAIL divu_lo: got %h want 7ffffffc", lo); end
        nCmp++; if (hi !== 32'h0000_0001) begin nErr++; $display("FAIL divu_hi: got %h want 00000001", hi); end
    endtask

    task automatic test_div_overflow;
        int w;
        @(negedge clk);
        go(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(30, w);
        nCmp++; if (w !== 10) begin nErr++; $display("FAIL ovf_latency: got %0d want 10", w); end
        nCmp++; if (lo !== 32'h8000_0000) begin nErr++; $display("FAIL ovf_lo: got %h want 80000000", lo); end
        nCmp++; if (hi !== 32'd0) begin nErr++; $display("FAIL ovf_hi: got %h want 0", hi); end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        start = 1'b1; op = 4'd5; rs_val = 32'h1234_5678;
        #1;
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL mthi_busy: got %b want 0", busy); end
        @(negedge clk);
        op = 4'd6; rs_val = 32'd9;
        #1;
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL mtlo_busy: got %b want 0", busy); end
        @(negedge clk);
        op = 4'd6; rs_val = 32'd5; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0; flush = 1'b0;
        nCmp++; if (hi !== 32'h1234_5678) begin nErr++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
        nCmp++; if (lo !== 32'd9) begin nErr++; $display("FAIL mtlo_lo: got %h want 00000009", lo); end
        nCmp++; if (done !== 1'b0) begin nErr++; $display("FAIL mtx_done: got %b want 0", done); end
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL mtx_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_flush;
        logic sawDone;
        @(negedge clk);
        go(4'd1, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        nCmp++; if (busy !== 1'b1) begin nErr++; $display("FAIL flush_busy_run: got %b want 1", busy); end
        @(negedge clk);
        flush = 1'b0;
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL flush_idle: got %b want 0", busy); end
        sawDone = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1) sawDone = 1'b1;
            @(negedge clk);
        end
        nCmp++; if (sawDone !== 1'b0) begin nErr++; $display("FAIL flush_done: got %b want 0", sawDone); end
        nCmp++; if (hi !== 32'h1234_5678) begin nErr++; $display("FAIL flush_hi: got %h want 12345678", hi); end
        nCmp++; if (lo !== 32'd9) begin nErr++; $display("FAIL flush_lo: got %h want 00000009", lo); end
    endtask

    task automatic test_reset_mid_run;
        logic sawDone;
        int w;
        @(negedge clk);
        go(4'd1, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        nCmp++; if (hi !== 32'd0) begin nErr++; $display("FAIL rst_run_hi: got %h want 0", hi); end
        nCmp++; if (lo !== 32'd0) begin nErr++; $display("FAIL rst_run_lo: got %h want 0", lo); end
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL rst_run_busy: got %b want 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        sawDone = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1) sawDone = 1'b1;
            @(negedge clk);
        end
        nCmp++; if (sawDone !== 1'b0) begin nErr++; $display("FAIL rst_run_done: got %b want 0", sawDone); end
        nCmp++; if (lo !== 32'd0) begin nErr++; $display("FAIL rst_run_lo_hold: got %h want 0", lo); end
        go(4'd2, 32'd6, 32'd7);
        waitDone(30, w);
        nCmp++; if (w !== 5) begin nErr++; $display("FAIL rst_after_latency: got %0d want 5", w); end
        nCmp++; if (lo !== 32'h0000_002A) begin nErr++; $display("FAIL rst_after_lo: got %h want 0000002a", lo); end
        nCmp++; if (hi !== 32'd0) begin nErr++; $display("FAIL rst_after_hi: got %h want 0", hi); end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd;
        int w;
        @(negedge clk);
        go(4'd6, 32'hFFFF_FFFF, 32'd0);
        go(4'd8, 32'd1, 32'd1);
        waitDone(30, w);
        nCmp++; if (w !== 5) begin nErr++; $display("FAIL maddu_latency: got %0d want 5", w); end
        nCmp++; if (hi !== 32'd1) begin nErr++; $display("FAIL maddu_hi: got %h want 00000001", hi); end
        nCmp++; if (lo !== 32'd0) begin nErr++; $display("FAIL maddu_lo: got %h want 0", lo); end
        @(negedge clk);
        go(4'd9, 32'd1, 32'd1);
        waitDone(30, w);
        nCmp++; if (w !== 5) begin nErr++; $display("FAIL msub_latency: got %0d want 5", w); end
        nCmp++; if (hi !== 32'd0) begin nErr++; $display("FAIL msub_hi: got %h want 0", hi); end
        nCmp++; if (lo !== 32'hFFFF_FFFF) begin nErr++; $display("FAIL msub_lo: got %h want ffffffff", lo); end
    endtask
`else
    task automatic test_madd;
        @(negedge clk);
        start = 1'b1; op = 4'd7; rs_val = 32'd1; rt_val = 32'd1;
        #1;
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL madd_off_busy: got %b want 0", busy); end
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL madd_off_busy2: got %b want 0", busy); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nCmp++; if (done !== 1'b0) begin nErr++; $display("FAIL madd_off_done c%0d: got %b want 0", k, done); end
        end
        nCmp++; if (hi !== 32'd0) begin nErr++; $display("FAIL madd_off_hi: got %h want 0", hi); end
        nCmp++; if (lo !== 32'h0000_002A) begin nErr++; $display("FAIL madd_off_lo: got %h want 0000002a", lo); end
    endtask
`endif

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_overflow();
        test_mthi_mtlo();
        test_flush();
        test_reset_mid_run();
        test_madd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
